vend_dp_multi: RTL and testbench

//  Parametrised vending datapath: N item channels, per-item prices, stock counters, credit

---
 rtl/vend_dp_multi_pkg.sv | 12 +
 rtl/vend_dp_multi_if.sv | 37 +++
 rtl/vend_dp_multi_change_disp.sv | 22 ++
 rtl/vend_dp_multi.sv | 109 ++++++++++
 tb/tb_vend_dp_multi.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/vend_dp_multi_pkg.sv
// vend_pkg: FSM states, coin encodings and coin values (quarter units) for the vending datapath
package vend_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_VEND, S_CHANGE} state_t;
  localparam logic [3:0] COIN_Q = 4'b0001, COIN_H = 4'b0010, COIN_D = 4'b0100, COIN_F = 4'b1000;
  localparam logic [2:0] CHG_Q = 3'b001, CHG_H = 3'b010, CHG_D = 3'b100;
  localparam int VAL_F = 20, VAL_D = 4, VAL_H = 2, VAL_Q = 1;
  // Anything other than exactly one coin bit is worth nothing and gets rejected
  function automatic logic [4:0] coin_value(input logic [3:0] c);
    return c == COIN_F ? 5'(VAL_F) : c == COIN_D ? 5'(VAL_D) :
           c == COIN_H ? 5'(VAL_H) : c == COIN_Q ? 5'(VAL_Q) : 5'd0;
  endfunction
endpackage

// File: rtl/vend_dp_multi_if.sv
// vend_dp_multi_if: front-end/ejector bus of the vending datapath; restock ports with VEND_RESTOCK_EN
interface vend_dp_multi_if #(parameter int N_ITEMS = 4, parameter int CREDIT_W = 10, parameter int STOCK_W = 8);
  logic [3:0]          in_coin;
  logic [N_ITEMS-1:0]  in_sel;
  logic                in_vend;
  logic                in_cancel;
  logic                in_change_ready;
`ifdef VEND_RESTOCK_EN
  logic [N_ITEMS-1:0]  in_restock;
  logic [STOCK_W-1:0]  in_restock_qty;
`endif
  logic [N_ITEMS-1:0]  out_stock;
  logic [N_ITEMS-1:0]  out_csel;
  logic [N_ITEMS-1:0]  out_spit;
  logic [CREDIT_W-1:0] out_credit;
  logic                out_short;
  logic                out_coin_reject;
  logic                out_change_valid;
  logic [2:0]          out_change_coin;
  logic                out_busy;
  modport master (
    output in_coin, in_sel, in_vend, in_cancel, in_change_ready,
`ifdef VEND_RESTOCK_EN
    output in_restock, in_restock_qty,
`endif
    input out_stock, out_csel, out_spit, out_credit, out_short, out_coin_reject,
    input out_change_valid, out_change_coin, out_busy
  );
  modport slave (
    input in_coin, in_sel, in_vend, in_cancel, in_change_ready,
`ifdef VEND_RESTOCK_EN
    input in_restock, in_restock_qty,
`endif
    output out_stock, out_csel, out_spit, out_credit, out_short, out_coin_reject,
    output out_change_valid, out_change_coin, out_busy
  );
endinterface

// File: rtl/vend_dp_multi_change_disp.sv
// vend_change_disp: greedy change coin select from the live credit, valid/ready handshake, done flag
module vend_change_disp
  import vend_pkg::*;
#(parameter int CREDIT_W = 10) (
  input  logic                active,
  input  logic                ready,
  input  logic [CREDIT_W-1:0] credit,
  output logic                valid,
  output logic [2:0]          coin,
  output logic [CREDIT_W-1:0] value,
  output logic                accept,
  output logic                done
);
  // Credit only moves on accept, so the presented coin stays stable while stalled
  always_comb begin
    valid  = active && credit != '0;
    value  = credit >= CREDIT_W'(VAL_D) ? CREDIT_W'(VAL_D) : credit >= CREDIT_W'(VAL_H) ? CREDIT_W'(VAL_H) : credit;
    coin   = !valid ? 3'b000 : value == CREDIT_W'(VAL_D) ? CHG_D : value == CREDIT_W'(VAL_H) ? CHG_H : CHG_Q;
    accept = valid && ready;
    done   = active && credit == '0;
  end
endmodule

// File: rtl/vend_dp_multi.sv
// vend_dp_multi: vending datapath with prices, stock, credit and change FSM; VEND_RESTOCK_EN adds restocking
module vend_dp_multi
  import vend_pkg::*;
#(
  parameter int N_ITEMS = 4,
  parameter int PRICE_W = 8,
  parameter logic [N_ITEMS*PRICE_W-1:0] ITEM_PRICES = {8'd14, 8'd12, 8'd10, 8'd8},
  parameter int CREDIT_W = 10,
  parameter int STOCK_W = 8,
  parameter int STOCK_INIT = 4
) (
  input logic          in_clk,
  input logic          in_restart_n,
  vend_dp_multi_if.slave bus
);
  state_t state, state_nx;
  logic [CREDIT_W-1:0] credit, credit_nx, chg_value;
  logic [N_ITEMS-1:0]  csel, csel_nx, spit;
  logic [STOCK_W-1:0]  stock [N_ITEMS];
  logic [STOCK_W-1:0]  stock_nx [N_ITEMS];
  logic [CREDIT_W:0]   total, csum;
  logic [4:0]          cval;
  logic                idle, coin_ok, short_p, reject, chg_valid, chg_accept, chg_done;
  logic [2:0]          chg_coin;
`ifdef VEND_RESTOCK_EN
  logic [STOCK_W:0]    rsum;
`endif
  vend_change_disp #(.CREDIT_W(CREDIT_W)) u_disp (
    .active(state == S_CHANGE), .ready(bus.in_change_ready), .credit(credit),
    .valid(chg_valid), .coin(chg_coin), .value(chg_value), .accept(chg_accept), .done(chg_done)
  );
  always_comb begin
    idle    = state == S_IDLE;
    cval    = coin_value(bus.in_coin);
    csum    = {1'b0, credit} + (CREDIT_W+1)'(cval);
    coin_ok = idle && cval != '0 && !csum[CREDIT_W];
    total   = '0;
    for (int i = 0; i < N_ITEMS; i++)
      total = total + (csel[i] ? (CREDIT_W+1)'(ITEM_PRICES[i*PRICE_W +: PRICE_W]) : '0);
  end
  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    csel_nx   = csel;
    stock_nx  = stock;
`ifdef VEND_RESTOCK_EN
    rsum      = '0;
`endif
    case (state)
      S_IDLE: begin
        credit_nx = coin_ok ? csum[CREDIT_W-1:0] : credit;
        for (int i = 0; i < N_ITEMS; i++)
          csel_nx[i] = bus.in_sel[i] ? (!csel[i] && stock[i] != '0) : csel[i];
`ifdef VEND_RESTOCK_EN
        for (int i = 0; i < N_ITEMS; i++) begin
          rsum = {1'b0, stock[i]} + {1'b0, bus.in_restock_qty};
          stock_nx[i] = !bus.in_restock[i] ? stock[i] : rsum[STOCK_W] ? '1 : rsum[STOCK_W-1:0];
        end
`endif
        csel_nx  = bus.in_cancel ? '0 : csel_nx;
        state_nx = bus.in_cancel ? S_CHANGE : (bus.in_vend && total != '0) ? S_CHECK : S_IDLE;
      end
      S_CHECK: state_nx = {1'b0, credit} >= total ? S_VEND : S_IDLE;
      S_VEND: begin
        credit_nx = credit - total[CREDIT_W-1:0];
        csel_nx   = '0;
        for (int i = 0; i < N_ITEMS; i++)
          stock_nx[i] = stock[i] - STOCK_W'(csel[i]);
        state_nx  = S_CHANGE;
      end
      S_CHANGE: begin
        credit_nx = chg_accept ? credit - chg_value : credit;
        state_nx  = chg_done ? S_IDLE : S_CHANGE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge in_clk) begin
    if (!in_restart_n) begin
      state   <= S_IDLE;
      credit  <= '0;
      csel    <= '0;
      spit    <= '0;
      short_p <= 1'b0;
      reject  <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state   <= state_nx;
      credit  <= credit_nx;
      csel    <= csel_nx;
      stock   <= stock_nx;
      spit    <= state == S_VEND ? csel : '0;
      short_p <= state == S_CHECK && {1'b0, credit} < total;
      reject  <= bus.in_coin != '0 && !coin_ok;
    end
  end
  always_comb begin
    bus.out_stock = '0;
    for (int i = 0; i < N_ITEMS; i++) bus.out_stock[i] = stock[i] != '0;
    bus.out_csel         = csel;
    bus.out_spit         = spit;
    bus.out_credit       = credit;
    bus.out_short        = short_p;
    bus.out_coin_reject  = reject;
    bus.out_change_valid = chg_valid;
    bus.out_change_coin  = chg_coin;
    bus.out_busy         = !idle;
  end
endmodule

// File: tb/tb_vend_dp_multi.sv
// tb_vend_dp_multi: directed scenario checks of the vending datapath against hand-computed values
module tb_vend_dp_multi;
  import vend_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  vend_dp_multi_if bus();
  vend_dp_multi dut (.in_clk(clk), .in_restart_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic coin(input logic [3:0] c);
    bus.in_coin = c; step(); bus.in_coin = '0;
  endtask
  task automatic sel(input int i);
    bus.in_sel = 4'(1 << i); step(); bus.in_sel = '0;
  endtask
  task automatic vend();
    bus.in_vend = 1'b1; step(); bus.in_vend = 1'b0;
  endtask
  task automatic cancel();
    bus.in_cancel = 1'b1; step(); bus.in_cancel = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.out_busy && n < max) begin step(); n++; end
    checks++;
    if (bus.out_busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", bus.out_busy, n); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_credit !== 10'd0) begin errors++; $display("FAIL rst_credit: got %0d want 0", bus.out_credit); end
    checks++; if (bus.out_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.out_busy); end
    checks++; if (bus.out_stock !== 4'hf) begin errors++; $display("FAIL rst_stock: got %b want 1111", bus.out_stock); end
    checks++; if ({bus.out_csel, bus.out_spit, bus.out_short, bus.out_coin_reject, bus.out_change_valid, bus.out_change_coin} !== 14'd0)
      begin errors++; $display("FAIL rst_outs: csel=%b spit=%b short=%b rej=%b cv=%b cc=%b want all 0", bus.out_csel, bus.out_spit,
        bus.out_short, bus.out_coin_reject, bus.out_change_valid, bus.out_change_coin); end
    vend();
    checks++; if (bus.out_busy !== 1'b0) begin errors++; $display("FAIL rst_empty_vend: busy=%b want 0", bus.out_busy); end
  endtask

  task automatic test_vend();
    coin(COIN_D); coin(COIN_D); coin(COIN_H);
    checks++; if (bus.out_credit !== 10'd10) begin errors++; $display("FAIL t1_credit: got %0d want 10", bus.out_credit); end
    sel(0);
    checks++; if (bus.out_csel !== 4'b0001) begin errors++; $display("FAIL t1_csel: got %b want 0001", bus.out_csel); end
    vend();
    checks++; if (bus.out_busy !== 1'b1 || bus.out_spit !== 4'b0) begin errors++; $display("FAIL t1_check: busy=%b spit=%b want 1/0000", bus.out_busy, bus.out_spit); end
    step();
    checks++; if (bus.out_spit !== 4'b0) begin errors++; $display("FAIL t1_spit_early: got %b want 0000", bus.out_spit); end
    step();
    checks++; if (bus.out_spit !== 4'b0001) begin errors++; $display("FAIL t1_spit: got %b want 0001", bus.out_spit); end
    checks++; if (bus.out_credit !== 10'd2 || bus.out_csel !== 4'b0) begin errors++; $display("FAIL t1_after_vend: credit=%0d csel=%b want 2/0000", bus.out_credit, bus.out_csel); end
    checks++; if (bus.out_change_valid !== 1'b1 || bus.out_change_coin !== CHG_H) begin errors++; $display("FAIL t1_change: valid=%b coin=%b want 1/010", bus.out_change_valid, bus.out_change_coin); end
    bus.in_change_ready = 1'b1; step(); bus.in_change_ready = 1'b0;
    checks++; if (bus.out_spit !== 4'b0 || bus.out_credit !== 10'd0) begin errors++; $display("FAIL t1_accept: spit=%b credit=%0d want 0000/0", bus.out_spit, bus.out_credit); end
    step();
    checks++; if (bus.out_busy !== 1'b0 || bus.out_change_valid !== 1'b0) begin errors++; $display("FAIL t1_idle: busy=%b valid=%b want 0/0", bus.out_busy, bus.out_change_valid); end
    checks++; if (bus.out_stock !== 4'hf) begin errors++; $display("FAIL t1_stock: got %b want 1111", bus.out_stock); end
  endtask

  task automatic test_short();
    coin(COIN_D); coin(COIN_D); coin(COIN_Q);
    sel(3);
    vend(); step();
    checks++; if (bus.out_short !== 1'b1 || bus.out_busy !== 1'b0) begin errors++; $display("FAIL t2_short: short=%b busy=%b want 1/0", bus.out_short, bus.out_busy); end
    checks++; if (bus.out_csel !== 4'b1000 || bus.out_credit !== 10'd9) begin errors++; $display("FAIL t2_kept: csel=%b credit=%0d want 1000/9", bus.out_csel, bus.out_credit); end
    step();
    checks++; if (bus.out_short !== 1'b0) begin errors++; $display("FAIL t2_pulse: short=%b want 0", bus.out_short); end
    cancel();
    checks++; if (bus.out_csel !== 4'b0) begin errors++; $display("FAIL t2_cancel_csel: got %b want 0000", bus.out_csel); end
    bus.in_change_ready = 1'b1; wait_idle(20); bus.in_change_ready = 1'b0;
    checks++; if (bus.out_credit !== 10'd0) begin errors++; $display("FAIL t2_refund: credit=%0d want 0", bus.out_credit); end
  endtask

  task automatic test_change();
    coin(COIN_D); coin(COIN_H); coin(COIN_Q);
    cancel();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.out_change_valid !== 1'b1 || bus.out_change_coin !== CHG_D || bus.out_credit !== 10'd7)
        begin errors++; $display("FAIL t3_hold%0d: valid=%b coin=%b credit=%0d want 1/100/7", k, bus.out_change_valid, bus.out_change_coin, bus.out_credit); end
      step();
    end
    bus.in_change_ready = 1'b1; step();
    checks++; if (bus.out_change_coin !== CHG_H || bus.out_credit !== 10'd3) begin errors++; $display("FAIL t3_second: coin=%b credit=%0d want 010/3", bus.out_change_coin, bus.out_credit); end
    step();
    checks++; if (bus.out_change_coin !== CHG_Q || bus.out_credit !== 10'd1) begin errors++; $display("FAIL t3_third: coin=%b credit=%0d want 001/1", bus.out_change_coin, bus.out_credit); end
    step(); bus.in_change_ready = 1'b0;
    checks++; if (bus.out_change_valid !== 1'b0 || bus.out_credit !== 10'd0) begin errors++; $display("FAIL t3_done: valid=%b credit=%0d want 0/0", bus.out_change_valid, bus.out_credit); end
    step();
    checks++; if (bus.out_busy !== 1'b0) begin errors++; $display("FAIL t3_idle: busy=%b want 0", bus.out_busy); end
  endtask

  task automatic test_stock_out();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      coin(COIN_D); coin(COIN_D); sel(0); vend();
      bus.in_change_ready = 1'b1; wait_idle(20); bus.in_change_ready = 1'b0;
      if (k == 2) begin
        checks++; if (bus.out_stock !== 4'hf) begin errors++; $display("FAIL t4_stock3: got %b want 1111", bus.out_stock); end
      end
    end
    checks++; if (bus.out_stock !== 4'b1110 || bus.out_credit !== 10'd0) begin errors++; $display("FAIL t4_empty: stock=%b credit=%0d want 1110/0", bus.out_stock, bus.out_credit); end
    sel(0);
    checks++; if (bus.out_csel !== 4'b0) begin errors++; $display("FAIL t4_sel_ignored: csel=%b want 0000", bus.out_csel); end
  endtask

  task automatic test_coin_reject();
    for (int k = 0; k < 50; k++) coin(COIN_F);
    for (int k = 0; k < 3; k++) begin coin(COIN_D); coin(COIN_Q); end
    checks++; if (bus.out_credit !== 10'd1015) begin errors++; $display("FAIL t5_credit: got %0d want 1015", bus.out_credit); end
    coin(COIN_F);
    checks++; if (bus.out_coin_reject !== 1'b1 || bus.out_credit !== 10'd1015) begin errors++; $display("FAIL t5_overflow: rej=%b credit=%0d want 1/1015", bus.out_coin_reject, bus.out_credit); end
    step();
    checks++; if (bus.out_coin_reject !== 1'b0) begin errors++; $display("FAIL t5_pulse: rej=%b want 0", bus.out_coin_reject); end
    coin(4'b0011);
    checks++; if (bus.out_coin_reject !== 1'b1 || bus.out_credit !== 10'd1015) begin errors++; $display("FAIL t5_multihot: rej=%b credit=%0d want 1/1015", bus.out_coin_reject, bus.out_credit); end
    cancel();
    coin(COIN_Q);
    checks++; if (bus.out_coin_reject !== 1'b1 || bus.out_credit !== 10'd1015 || bus.out_busy !== 1'b1)
      begin errors++; $display("FAIL t5_busy_coin: rej=%b credit=%0d busy=%b want 1/1015/1", bus.out_coin_reject, bus.out_credit, bus.out_busy); end
  endtask

  task automatic test_reset_mid_change();
    bus.in_change_ready = 1'b1; step(); step();
    checks++; if (bus.out_credit !== 10'd1007 || bus.out_change_valid !== 1'b1) begin errors++; $display("FAIL t6_draining: credit=%0d valid=%b want 1007/1", bus.out_credit, bus.out_change_valid); end
    rst_n = 1'b0; step(); rst_n = 1'b1; bus.in_change_ready = 1'b0;
    checks++; if (bus.out_busy !== 1'b0 || bus.out_credit !== 10'd0 || bus.out_change_valid !== 1'b0 || bus.out_change_coin !== 3'b0)
      begin errors++; $display("FAIL t6_reset: busy=%b credit=%0d valid=%b coin=%b want 0/0/0/000", bus.out_busy, bus.out_credit, bus.out_change_valid, bus.out_change_coin); end
    checks++; if (bus.out_stock !== 4'hf) begin errors++; $display("FAIL t6_stock: got %b want 1111", bus.out_stock); end
  endtask

  initial begin
    bus.in_coin = '0; bus.in_sel = '0; bus.in_vend = 1'b0; bus.in_cancel = 1'b0; bus.in_change_ready = 1'b0;
`ifdef VEND_RESTOCK_EN
    bus.in_restock = '0; bus.in_restock_qty = '0;
`endif
    test_reset();
    test_vend();
    test_short();
    test_change();
    test_stock_out();
    test_coin_reject();
    test_reset_mid_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
